// File: rtl/uvmt_cv32e40s_support_logic_pkg.sv
// Shared support-logic types for the OBI phase monitor.
package uvmt_cv32e40s_support_logic_pkg;

    // Address-phase tracking state: idle, or a request is waiting for its grant.
    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_GNT = 1'b1
    } obi_addr_ph_state_e;

    // Counter width needed to hold 0..max_outstanding.
    function automatic int cnt_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/uvmt_cv32e40s_sl_obi_phase_monitor_if.sv
// OBI handshake signals observed by the phase monitor.
interface uvmt_cv32e40s_sl_obi_phase_monitor_if #(
    parameter int XLEN = 1
);
    logic            req;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] req_attribute_i;

    // Manager side drives the request and its attribute.
    modport master (output req, req_attribute_i, input gnt, rvalid);
    // Subordinate side drives grant and response valid.
    modport slave  (input req, req_attribute_i, output gnt, rvalid);
    // Passive observer.
    modport monitor (input req, gnt, rvalid, req_attribute_i);
endinterface

// File: rtl/uvmt_cv32e40s_sl_obi_outstanding_cnt.sv
// Saturating up/down count of accepted requests awaiting rvalid.
module uvmt_cv32e40s_sl_obi_outstanding_cnt
    import uvmt_cv32e40s_support_logic_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   inc_i,
    input  logic                                   rvalid_i,
    output logic [cnt_width(MAX_OUTSTANDING)-1:0]  cnt_o,
    output logic                                   overflow_o,
    output logic                                   underflow_o
);
    localparam int CW = cnt_width(MAX_OUTSTANDING);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          dec;

    // A response only retires something already outstanding, never this cycle's acceptance.
    assign dec = rvalid_i && (cnt_q != '0);

    // Next count: +1 saturating, -1, or hold when both or neither apply.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec) begin
            cnt_d = (cnt_q == MAX_CNT) ? MAX_CNT : cnt_q + CW'(1);
        end else if (dec && !inc_i) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o       = cnt_q;
    assign underflow_o = rvalid_i && (cnt_q == '0);
    assign overflow_o  = inc_i && !rvalid_i && (cnt_q == MAX_CNT);
endmodule

// File: rtl/uvmt_cv32e40s_sl_obi_phase_monitor.sv
// OBI address/response phase monitor: acceptance strobes, outstanding
// count, and protocol error pulses with a sticky summary.
module uvmt_cv32e40s_sl_obi_phase_monitor
    import uvmt_cv32e40s_support_logic_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int XLEN            = 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    uvmt_cv32e40s_sl_obi_phase_monitor_if.monitor  bus,
    output logic                                   addr_ph_accept_o,
    output logic                                   resp_ph_accept_o,
    output logic [cnt_width(MAX_OUTSTANDING)-1:0]  outstanding_o,
    output logic                                   err_req_dropped_o,
    output logic                                   err_attr_changed_o,
    output logic                                   err_overflow_o,
    output logic                                   err_underflow_o,
    output logic                                   err_sticky_o
);
    obi_addr_ph_state_e state_q, state_d;
    logic [XLEN-1:0]    held_attr_q;
    logic               err_sticky_q;
    logic               cnt_ovf, cnt_unf;
    logic               any_err;

    // Zero-latency strobes for the downstream attribute FIFO.
    assign addr_ph_accept_o = bus.req && bus.gnt;
    assign resp_ph_accept_o = bus.rvalid;

    assign state_d = (bus.req && !bus.gnt) ? S_WAIT_GNT : S_IDLE;

    uvmt_cv32e40s_sl_obi_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inc_i       (addr_ph_accept_o),
        .rvalid_i    (bus.rvalid),
        .cnt_o       (outstanding_o),
        .overflow_o  (cnt_ovf),
        .underflow_o (cnt_unf)
    );

    // Protocol checks only apply while a request is stalled; all pulses are masked in reset.
    always_comb begin
        err_req_dropped_o  = 1'b0;
        err_attr_changed_o = 1'b0;
        if (!rst_i && state_q == S_WAIT_GNT) begin
            err_req_dropped_o  = !bus.req;
            err_attr_changed_o = bus.req && (bus.req_attribute_i != held_attr_q);
        end
        err_overflow_o  = !rst_i && cnt_ovf;
        err_underflow_o = !rst_i && cnt_unf;
    end

    assign any_err = err_req_dropped_o | err_attr_changed_o | err_overflow_o | err_underflow_o;

    // Phase FSM, attribute capture on entry to S_WAIT_GNT, and sticky error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            held_attr_q  <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && state_d == S_WAIT_GNT) begin
                held_attr_q <= bus.req_attribute_i;
            end
            err_sticky_q <= err_sticky_q | any_err;
        end
    end

    assign err_sticky_o = err_sticky_q;
endmodule

// File: tb/tb_uvmt_cv32e40s_sl_obi_phase_monitor.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic against a cycle-level behavioural model.
module tb_uvmt_cv32e40s_sl_obi_phase_monitor;
    localparam int MAX = 2;
    localparam int XLEN = 4;
    localparam int CW = $clog2(MAX + 1);

    logic clk = 1'b0;
    logic rst;
    logic addr_acc, resp_acc, e_drop, e_attr, e_ovf, e_unf, e_sticky;
    logic [CW-1:0] outst;

    uvmt_cv32e40s_sl_obi_phase_monitor_if #(.XLEN(XLEN)) bus ();

    uvmt_cv32e40s_sl_obi_phase_monitor #(.MAX_OUTSTANDING(MAX), .XLEN(XLEN)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .bus                (bus),
        .addr_ph_accept_o   (addr_acc),
        .resp_ph_accept_o   (resp_acc),
        .outstanding_o      (outst),
        .err_req_dropped_o  (e_drop),
        .err_attr_changed_o (e_attr),
        .err_overflow_o     (e_ovf),
        .err_underflow_o    (e_unf),
        .err_sticky_o       (e_sticky)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Behavioural model: is a request stalled, what attribute it was
    // presented with, how many accepted requests await a response, sticky.
    bit            m_wait;
    logic [XLEN-1:0] m_held;
    int            m_cnt;
    bit            m_sticky;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive after the edge, compare mid-cycle, advance model.
    task automatic cycle(input bit r, input bit g, input bit v, input logic [XLEN-1:0] a, input bit rs);
        bit x_drop, x_attr, x_ovf, x_unf, acc, nwait;
        int ret;
        @(posedge clk);
        #1;
        bus.req = r; bus.gnt = g; bus.rvalid = v; bus.req_attribute_i = a; rst = rs;
        #4;
        acc    = r && g;
        x_drop = !rs && m_wait && !r;
        x_attr = !rs && m_wait && r && (a != m_held);
        x_unf  = !rs && v && (m_cnt == 0);
        x_ovf  = !rs && acc && !v && (m_cnt == MAX);
        chk("addr_ph_accept", int'(addr_acc), int'(acc));
        chk("resp_ph_accept", int'(resp_acc), int'(v));
        chk("outstanding", int'(outst), m_cnt);
        chk("err_req_dropped", int'(e_drop), int'(x_drop));
        chk("err_attr_changed", int'(e_attr), int'(x_attr));
        chk("err_overflow", int'(e_ovf), int'(x_ovf));
        chk("err_underflow", int'(e_unf), int'(x_unf));
        chk("err_sticky", int'(e_sticky), int'(m_sticky));
        if (rs) begin
            m_wait = 0; m_held = '0; m_cnt = 0; m_sticky = 0;
        end else begin
            m_sticky = m_sticky | x_drop | x_attr | x_ovf | x_unf;
            ret = (v && m_cnt > 0) ? 1 : 0;
            m_cnt = m_cnt + int'(acc) - ret;
            if (m_cnt > MAX) m_cnt = MAX;
            nwait = r && !g;
            if (nwait && !m_wait) m_held = a;
            m_wait = nwait;
        end
    endtask

    task automatic idle();
        cycle(0, 0, 0, '0, 0);
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, '0, 1);
    endtask

    initial begin
        bus.req = 0; bus.gnt = 0; bus.rvalid = 0; bus.req_attribute_i = '0; rst = 1;
        repeat (2) @(posedge clk);
        m_wait = 0; m_held = '0; m_cnt = 0; m_sticky = 0;
        do_reset();

        // Reset state
        idle();
        chk("reset_outstanding", int'(outst), 0);
        chk("reset_sticky", int'(e_sticky), 0);

        // Two accepts then two responses: 0,1,2,1,0
        cycle(1, 1, 0, 4'h3, 0); chk("seq_out0", int'(outst), 0);
        cycle(1, 1, 0, 4'h5, 0); chk("seq_out1", int'(outst), 1);
        cycle(0, 0, 1, '0, 0);   chk("seq_out2", int'(outst), 2);
        cycle(0, 0, 1, '0, 0);   chk("seq_out3", int'(outst), 1);
        idle();                  chk("seq_out4", int'(outst), 0);
        chk("seq_no_err", int'(e_sticky), 0);

        // Attribute changes on the grant cycle
        repeat (3) cycle(1, 0, 0, 4'h1, 0);
        cycle(1, 1, 0, 4'h0, 0); chk("attr_chg_pulse", int'(e_attr), 1);
        idle();                  chk("attr_chg_sticky", int'(e_sticky), 1);
        do_reset();

        // Request dropped before grant
        cycle(1, 0, 0, 4'h2, 0);
        cycle(0, 0, 0, 4'h2, 0); chk("req_dropped_pulse", int'(e_drop), 1);
        do_reset();

        // Overflow at MAX, then legal accept+response at MAX
        cycle(1, 1, 0, '0, 0);
        cycle(1, 1, 0, '0, 0);
        cycle(1, 1, 0, '0, 0);   chk("ovf_pulse", int'(e_ovf), 1);
        cycle(1, 1, 1, '0, 0);   chk("ovf_cnt_held", int'(outst), 2);
        chk("ovf_legal_noerr", int'(e_ovf), 0);
        idle();                  chk("ovf_cnt_after_legal", int'(outst), 2);
        do_reset();

        // Underflow with simultaneous accept
        cycle(1, 1, 1, '0, 0);   chk("unf_pulse", int'(e_unf), 1);
        idle();                  chk("unf_cnt_next", int'(outst), 1);
        do_reset();

        // Reset mid-transaction discards everything
        cycle(1, 1, 0, '0, 0);
        cycle(1, 1, 0, '0, 0);
        cycle(1, 0, 0, 4'h7, 0);
        cycle(1, 0, 0, 4'h9, 1); chk("rst_mask_attr", int'(e_attr), 0);
        idle();
        chk("rst_cnt_cleared", int'(outst), 0);
        chk("rst_sticky_clear", int'(e_sticky), 0);
        chk("rst_state_idle", int'(e_drop), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, g, v, rs;
            logic [XLEN-1:0] a;
            r  = ($urandom_range(0, 99) < 60);
            g  = ($urandom_range(0, 99) < 50);
            v  = ($urandom_range(0, 99) < 40);
            rs = ($urandom_range(0, 99) < 2);
            a  = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 3)) : bus.req_attribute_i;
            cycle(r, g, v, a, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uvmt_cv32e40s_sl_obi_phase_monitor.md
UVMT_CV32E40S_SL_OBI_PHASE_MONITOR -- requirements
Module: uvmt_cv32e40s_sl_obi_phase_monitor

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 2: maximum number of accepted requests still awaiting rvalid; legal range 1..15.
REQ-002 Parameter XLEN, default 1: width of the request attribute.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset; synchronous and active-high.
REQ-005 req  input  1  OBI address-phase request.
REQ-006 gnt  input  1  OBI address-phase grant.
REQ-007 rvalid  input  1  OBI response-phase valid.
REQ-008 req_attribute_i  input  XLEN  attribute driven with req.
REQ-009 addr_ph_accept_o  output  1  address phase accepted this cycle (req && gnt).
REQ-010 resp_ph_accept_o  output  1  response accepted this cycle (rvalid).
REQ-011 outstanding_o  output  CW = $clog2(MAX_OUTSTANDING+1)  count of accepted requests awaiting response.
REQ-012 err_req_dropped_o  output  1  pulse: req deasserted before gnt.
REQ-013 err_attr_changed_o  output  1  pulse: attribute changed while the request waits for gnt.
REQ-014 err_overflow_o  output  1  pulse: acceptance beyond MAX_OUTSTANDING.
REQ-015 err_underflow_o  output  1  pulse: rvalid with no outstanding request.
REQ-016 err_sticky_o  output  1  OR of all error pulses since reset, registered.

Function
REQ-017 addr_ph_accept_o SHALL equal req && gnt and resp_ph_accept_o SHALL equal rvalid, both combinational with zero latency; this pair feeds the downstream request-attribute FIFO.
REQ-018 FSM states: S_IDLE and S_WAIT_GNT; next state SHALL be S_WAIT_GNT when req && !gnt, otherwise S_IDLE.
REQ-019 On every transition into S_WAIT_GNT, and while S_WAIT_GNT persists, held_attr SHALL load req_attribute_i only on the entry cycle.
REQ-020 In S_WAIT_GNT, err_req_dropped_o SHALL be 1 in any cycle with !req, combinational.
REQ-021 In S_WAIT_GNT with req high, err_attr_changed_o SHALL be 1 when req_attribute_i != held_attr, combinational; this includes the cycle that gnt arrives.
REQ-022 In S_IDLE, err_req_dropped_o and err_attr_changed_o SHALL be 0.
REQ-023 Counter update: inc = addr_ph_accept_o; dec = rvalid && (outstanding_o != 0).
REQ-024 A response in the same cycle as an acceptance SHALL never retire that acceptance.
REQ-025 Next count: inc && !dec gives +1, saturating at MAX_OUTSTANDING; dec && !inc gives -1; inc && dec gives unchanged.
REQ-026 err_underflow_o SHALL be rvalid && outstanding_o == 0, combinational; on underflow, inc alone is applied.
REQ-027 err_overflow_o SHALL be inc && !rvalid && outstanding_o == MAX_OUTSTANDING, combinational; on overflow the count stays MAX_OUTSTANDING.
REQ-028 inc && rvalid at outstanding_o == MAX_OUTSTANDING SHALL be legal, with the count unchanged.
REQ-029 err_sticky_o SHALL be set on the cycle after any error pulse and SHALL hold until reset.

Reset
REQ-030 While rst_i is high at a clock edge, the block SHALL set state=S_IDLE, outstanding_o=0, held_attr=0, and err_sticky_o=0.
REQ-031 While rst_i is high, all err_*_o pulse outputs SHALL be forced to 0.
REQ-032 A reset asserted mid-transaction SHALL discard all outstanding and pending state with no error reported.

Structure
REQ-033 The state typedef (S_IDLE=0, S_WAIT_GNT=1) SHALL reside in the shared support-logic package, uvmt_cv32e40s_support_logic_pkg.
REQ-034 The saturating up/down counter with underflow/overflow flags SHALL be the sub-module uvmt_cv32e40s_sl_obi_outstanding_cnt, parameterised by MAX_OUTSTANDING.

Verification
REQ-035 Scenario: req=1,gnt=1 at cycles 1 and 2, then rvalid at cycles 3 and 4 -> outstanding_o 0,1,2,1,0; no errors.
REQ-036 Scenario: req=1,gnt=0, attr=1 for 3 cycles, then gnt=1 with attr=0 -> err_attr_changed_o=1 on the gnt cycle; err_sticky_o=1 next cycle.
REQ-037 Scenario: req=1,gnt=0 for 1 cycle, then req=0 -> err_req_dropped_o=1 in the req=0 cycle.
REQ-038 Scenario: MAX_OUTSTANDING=2 and outstanding_o=2, then req&&gnt&&!rvalid -> err_overflow_o=1 and the count stays 2; the same with rvalid=1 -> no error and the count stays 2.
REQ-039 Scenario: outstanding_o=0 with rvalid=1 and req&&gnt=1 -> err_underflow_o=1 and outstanding_o=1 next cycle.
REQ-040 Scenario: rst_i=1 for one cycle while outstanding_o=2 and state=S_WAIT_GNT -> next cycle outstanding_o=0, S_IDLE, err_sticky_o=0, no error pulses.
